// File: rtl/mem_wb_stage.sv
// Combined memory-access and write-back stage: one operation in flight, optional
// 64-bit load/store against an internal word-addressed memory, registered RF write port.
module mem_wb_stage #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    // Handshake: an operation transfers on a rising edge where in_valid && in_ready.
    // Upstream holds its operation while in_ready is low; inputs are sampled only at transfer.
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWriteIn,
    input  logic [4:0]  Rd,
    input  logic [63:0] ALUResult,
    input  logic [63:0] StoreData,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [63:0] WriteData,
    output logic        error,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        memtoreg_q, memtoreg_d;
    logic        regwrite_in_q, regwrite_in_d;
    logic [4:0]  rd_q, rd_d;
    logic [63:0] alu_q, alu_d;
    logic [63:0] store_q, store_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [63:0] write_data_q, write_data_d;
    logic        error_q, error_d;

    logic [63:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] acc_idx;
    logic          in_is_mem;
    logic          in_reject;

    assign acc_idx   = alu_q[AW+2:3];
    assign in_is_mem = MemRead | MemWrite;
    assign in_reject = (MemRead & MemWrite) | (in_is_mem & (ALUResult[2:0] != 3'd0));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        memtoreg_d    = memtoreg_q;
        regwrite_in_d = regwrite_in_q;
        rd_d          = rd_q;
        alu_d         = alu_q;
        store_d       = store_q;
        reg_write_d   = reg_write_q;
        write_reg_d   = write_reg_q;
        write_data_d  = write_data_q;
        error_d       = 1'b0;
        mem_we        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_reject) begin
                        error_d = 1'b1;
                    end else if (!in_is_mem) begin
                        // ALU op needs no memory: go straight to write-back.
                        state_d      = S_WB;
                        reg_write_d  = RegWriteIn && (Rd != 5'd31);
                        write_reg_d  = Rd;
                        write_data_d = ALUResult;
                    end else begin
                        state_d       = S_ACCESS;
                        cnt_d         = 4'(LATENCY - 1);
                        mem_read_d    = MemRead;
                        mem_write_d   = MemWrite;
                        memtoreg_d    = MemtoReg;
                        regwrite_in_d = RegWriteIn;
                        rd_d          = Rd;
                        alu_d         = ALUResult;
                        store_d       = StoreData;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Final access edge: commit store / capture load data.
                    mem_we       = mem_write_q;
                    state_d      = S_WB;
                    reg_write_d  = regwrite_in_q && (rd_q != 5'd31) && !mem_write_q;
                    write_reg_d  = rd_q;
                    write_data_d = (mem_read_q && memtoreg_q) ? mem[acc_idx] : alu_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WB: begin
                state_d     = S_IDLE;
                reg_write_d = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                reg_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            memtoreg_q    <= 1'b0;
            regwrite_in_q <= 1'b0;
            rd_q          <= 5'd0;
            alu_q         <= 64'd0;
            store_q       <= 64'd0;
            reg_write_q   <= 1'b0;
            write_reg_q   <= 5'd0;
            write_data_q  <= 64'd0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            memtoreg_q    <= memtoreg_d;
            regwrite_in_q <= regwrite_in_d;
            rd_q          <= rd_d;
            alu_q         <= alu_d;
            store_q       <= store_d;
            reg_write_q   <= reg_write_d;
            write_reg_q   <= write_reg_d;
            write_data_q  <= write_data_d;
            error_q       <= error_d;
        end
    end

    // Memory contents survive reset; mem_we is gated by state, which reset clears.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[acc_idx] <= store_q;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign RegWrite  = reg_write_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;
    assign error     = error_q;
    assign dbg_state = state_q;

endmodule
